// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: oversampling UART receiver, 8 data bits LSB first, 1 start, 1 stop.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_8n1 #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_error
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_M1  = DW'(DIV - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic          rx_s1, rx_s;
    logic [DW-1:0] div_cnt;
    logic          tick;

    state_t        state, state_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, sh_n;
    logic [7:0]    data_n;
    logic          ready_n, error_n;
`ifdef UART_RX_PARITY_EN
    logic          par_bad, par_n;
`endif

    // two-flop synchronizer, idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s  <= rx_s1;
        end
    end

    // free-running oversample tick divider, never realigned to start edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_cnt <= '0;
        else if (div_cnt == DIV_M1) div_cnt <= '0;
        else div_cnt <= div_cnt + DW'(1);
    end

    assign tick = (div_cnt == DIV_M1);

    // frame state, position counters, shift register and registered strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_ready <= 1'b0;
            rx_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= sh_n;
            rx_data  <= data_n;
            rx_ready <= ready_n;
            rx_error <= error_n;
`ifdef UART_RX_PARITY_EN
            par_bad  <= par_n;
`endif
        end
    end

    // next-state and datapath decode; strobes default low every cycle
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        data_n  = rx_data;
        ready_n = 1'b0;
        error_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_bad;
`endif
        case (state)
            S_IDLE: begin
                tick_n = '0;
                bit_n  = '0;
`ifdef UART_RX_PARITY_EN
                par_n  = 1'b0;
`endif
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (tick) begin
                    if (tick_cnt == HALF_M1) begin
                        tick_n  = '0;
                        // still high at mid start bit: a glitch, drop it silently
                        state_n = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tick_cnt == FULL_M1) begin
                        tick_n = '0;
                        sh_n   = {rx_s, shreg[7:1]};
                        bit_n  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = S_PARITY;
`else
                            state_n = S_STOP;
`endif
                        end
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (tick_cnt == FULL_M1) begin
                        tick_n  = '0;
                        // even parity: data bits plus parity bit must XOR to 0
                        par_n   = ^{shreg, rx_s};
                        state_n = S_STOP;
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (tick_cnt == FULL_M1) begin
                        tick_n = '0;
                        if (rx_s) begin
                            // leave at mid stop bit so a back-to-back start is caught
                            state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                error_n = 1'b1;
                            end else begin
                                data_n  = shreg;
                                ready_n = 1'b1;
                            end
`else
                            data_n  = shreg;
                            ready_n = 1'b1;
`endif
                        end else begin
                            error_n = 1'b1;
                            state_n = S_BREAK;
                        end
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            S_BREAK: begin
                // held-low line: one error only, wait for the line to recover
                tick_n = '0;
                bit_n  = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed bench for uart_rx_8n1 at default parameters.
module tb_uart_rx_8n1;

    localparam int BITC = 864;   // 54 clk per tick * 16 ticks per bit

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_error;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] got[$];
    int         err_cnt = 0;
    int         both_cnt = 0;
    time        t_rdy = 0;
    time        t_start = 0;

    uart_rx_8n1 dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_error (rx_error)
    );

    always #5 clk = ~clk;

    // strobe monitor, sampled on the falling edge away from register updates
    always @(negedge clk) begin
        if (rx_ready) begin
            got.push_back(rx_data);
            t_rdy = $time;
        end
        if (rx_error) err_cnt++;
        if (rx_ready && rx_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int bitc);
        rx = b;
        repeat (bitc) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int bitc, input logic par_flip);
        t_start = $time;
        send_bit(1'b0, bitc);
        for (int i = 0; i < 8; i++) send_bit(b[i], bitc);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_flip, bitc);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        send_bit(stop, bitc);
        rx = 1'b1;
    endtask

    task automatic idle(input int cyc);
        rx = 1'b1;
        repeat (cyc) @(negedge clk);
    endtask

    initial begin
        time lat;
        repeat (5) @(negedge clk);
        check("rst_data", {24'h0, rx_data}, 32'h00);
        check("rst_ready", {31'h0, rx_ready}, 32'h0);
        check("rst_error", {31'h0, rx_error}, 32'h0);
        reset = 1'b1;
        idle(200);

        // single byte with latency window
        send_byte(8'hA5, 1'b1, BITC, 1'b0);
        idle(200);
        check("a5_count", got.size(), 1);
        check("a5_data", {24'h0, got[0]}, 32'hA5);
        check("a5_noerr", err_cnt, 0);
        lat = (t_rdy - t_start) / 10;
        check("a5_latency", {31'h0, (lat >= 8150 && lat <= 8280)}, 32'h1);

        // framing error followed by a long break
        send_byte(8'h3C, 1'b0, BITC, 1'b0);
        rx = 1'b0;
        repeat (20 * BITC) @(negedge clk);
        idle(2 * BITC);
        check("brk_errs", err_cnt, 1);
        check("brk_count", got.size(), 1);
        check("brk_hold", {24'h0, rx_data}, 32'hA5);

        send_byte(8'h3C, 1'b1, BITC, 1'b0);
        idle(200);
        check("3c_count", got.size(), 2);
        check("3c_data", {24'h0, got[1]}, 32'h3C);

        // back-to-back frames, no idle gap
        send_byte(8'h01, 1'b1, BITC, 1'b0);
        send_byte(8'hFF, 1'b1, BITC, 1'b0);
        send_byte(8'h80, 1'b1, BITC, 1'b0);
        idle(200);
        check("b2b_count", got.size(), 5);
        check("b2b_0", {24'h0, got[2]}, 32'h01);
        check("b2b_1", {24'h0, got[3]}, 32'hFF);
        check("b2b_2", {24'h0, got[4]}, 32'h80);

        // short low glitch must be rejected
        rx = 1'b0;
        repeat (162) @(negedge clk);
        idle(2000);
        check("glitch_count", got.size(), 5);
        check("glitch_err", err_cnt, 1);
        send_byte(8'h5A, 1'b1, BITC, 1'b0);
        idle(200);
        check("5a_count", got.size(), 6);
        check("5a_data", {24'h0, got[5]}, 32'h5A);

        // asynchronous reset in the middle of bit 4, held past the frame end
        fork
            send_byte(8'h96, 1'b1, BITC, 1'b0);
            begin
                repeat (5 * BITC + 400) @(negedge clk);
                #2 reset = 1'b0;
                #1;
                check("mid_rst_data", {24'h0, rx_data}, 32'h00);
                check("mid_rst_ready", {31'h0, rx_ready}, 32'h0);
                repeat (5 * BITC) @(negedge clk);
                reset = 1'b1;
            end
        join
        idle(2 * BITC);
        check("96_count", got.size(), 6);
        check("96_err", err_cnt, 1);
        send_byte(8'hC3, 1'b1, BITC, 1'b0);
        idle(200);
        check("c3_count", got.size(), 7);
        check("c3_data", {24'h0, got[6]}, 32'hC3);

        // baud mismatch +2.5% / -2.5%
        send_byte(8'h55, 1'b1, 886, 1'b0);
        idle(200);
        check("slow_count", got.size(), 8);
        check("slow_data", {24'h0, got[7]}, 32'h55);
        send_byte(8'h55, 1'b1, 842, 1'b0);
        idle(200);
        check("fast_count", got.size(), 9);
        check("fast_data", {24'h0, got[8]}, 32'h55);

`ifdef UART_RX_PARITY_EN
        send_byte(8'h07, 1'b1, BITC, 1'b1);
        idle(200);
        check("par_err", err_cnt, 2);
        check("par_count", got.size(), 9);
        check("par_hold", {24'h0, rx_data}, 32'h55);
`endif

        check("final_err", err_cnt, 1
`ifdef UART_RX_PARITY_EN
            + 1
`endif
        );
        check("never_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
